multi_channel_match_monitor: RTL

//   Parametrised per-channel value monitor. Registers NCH valid/data streams and

---
 rtl/multi_channel_match_monitor.sv | 116 +++++++++++
 1 files changed

// File: rtl/multi_channel_match_monitor.sv
// rtl/multi_channel_match_monitor.sv - per-channel match monitor: sticky hit, pulse, saturating count, first-hit time
module multi_channel_match_monitor #(
   parameter int                NCH       = 4,
   parameter int                WIDTH     = 3,
   parameter int                CNT_W     = 8,
   parameter int                TS_W      = 16,
   parameter logic [WIDTH-1:0]  IDLE_DATA = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  arm_i,
   input  logic                  clr_i,
   input  logic [WIDTH-1:0]      match_val_i,
   input  logic [NCH-1:0]        in_valid_i,
   input  logic [NCH*WIDTH-1:0]  in_data_i,
   output logic [NCH*WIDTH-1:0]  data_q_o,
   output logic [NCH-1:0]        hit_o,
   output logic [NCH-1:0]        hit_pulse_o,
   output logic [NCH*CNT_W-1:0]  hit_count_o,
   output logic [NCH*TS_W-1:0]   hit_time_o,
   output logic                  any_hit_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_HIT   = 2'd2
   } state_t;

   logic [TS_W-1:0] ts_q;
   logic [NCH-1:0]  hit_d;
   logic            any_hit_q;

   // Free-running cycle timestamp, only reset clears it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      state_t           state_q;
      logic [WIDTH-1:0] data_q;
      logic             hit_q;
      logic             pulse_q;
      logic [CNT_W-1:0] cnt_q;
      logic [TS_W-1:0]  time_q;
      logic [WIDTH-1:0] din;
      logic             match;

      assign din   = in_data_i[c*WIDTH +: WIDTH];
      assign match = in_valid_i[c] && (din == match_val_i);

      // Next sticky hit; shared with any_hit so both registers move together
      assign hit_d[c] = !clr_i && (hit_q || ((state_q == S_ARMED) && match));

      // Per-channel data capture and IDLE/ARMED/HIT tracking with registered outputs
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q <= S_IDLE;
            data_q  <= IDLE_DATA;
            hit_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            time_q  <= '0;
         end else begin
            data_q  <= in_valid_i[c] ? din : IDLE_DATA;
            hit_q   <= hit_d[c];
            pulse_q <= 1'b0;
            if (clr_i) begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               time_q  <= '0;
            end else begin
               case (state_q)
                  S_IDLE: begin
                     if (arm_i) state_q <= S_ARMED;
                  end
                  S_ARMED: begin
                     if (match) begin
                        state_q <= S_HIT;
                        pulse_q <= 1'b1;
                        time_q  <= ts_q;
                        cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                     end
                  end
                  S_HIT: begin
                     if (match) cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                  end
                  default: state_q <= S_IDLE;
               endcase
            end
         end
      end

      assign data_q_o[c*WIDTH +: WIDTH]   = data_q;
      assign hit_o[c]                     = hit_q;
      assign hit_pulse_o[c]               = pulse_q;
      assign hit_count_o[c*CNT_W +: CNT_W] = cnt_q;
      assign hit_time_o[c*TS_W +: TS_W]    = time_q;
   end

   // Summary flag registered from next-state hits so it tracks hit_o exactly
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         any_hit_q <= 1'b0;
      end else begin
         any_hit_q <= |hit_d;
      end
   end

   assign any_hit_o = any_hit_q;

endmodule
